// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - register map, register layouts and FSM states for the SPI slave
package spi_slave_pkg;

  localparam int spi_s_depth  = 8;
  localparam int spi_s_sync_w = 2;

  localparam logic [4:0] addr_cr    = 5'h00;
  localparam logic [4:0] addr_dr    = 5'h04;
  localparam logic [4:0] addr_sr    = 5'h08;
  localparam logic [4:0] addr_irq_m = 5'h0C;
  localparam logic [4:0] addr_irq_v = 5'h10;

  typedef struct packed {
    logic [3:0] rx_fifo_lvl;
    logic       en;
    logic       msb_lsb;
    logic       cpha;
    logic       cpol;
  } spi_s_cr_v;

  typedef struct packed {
    logic busy;
    logic udr;
    logic ovr;
    logic tx_full;
    logic tx_emp;
    logic rx_full;
    logic rx_emp;
  } spi_s_sr_v;

  typedef struct packed {
    logic frame_end;
    logic udr;
    logic ovr;
    logic tx_emp;
    logic rx_full;
  } spi_s_irq_v;

  typedef enum logic [1:0] {
    st_idle,
    st_load,
    st_shift
  } spi_s_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - peripheral register bus for the SPI slave
//   addr/re/we/wd : bus request from the host
//   rd/irq        : read data and interrupt back to the host
interface spi_slave_if;
  logic [4:0]  addr;
  logic        re;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (output addr, re, we, wd, input rd, irq);
  modport slave  (input addr, re, we, wd, output rd, irq);
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead FIFO with occupancy count
//   push/din : write side, ignored when full unless a pop happens in the same clk
//   pop/dout : read side; when empty dout holds the last popped head
//   count    : current occupancy
module fifo #(
  parameter int depth  = 8,
  parameter int data_w = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [data_w-1:0]            din,
  input  logic                         pop,
  output logic [data_w-1:0]            dout,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);

  logic [data_w-1:0] mem [depth];
  logic [aw-1:0]     wr_ptr;
  logic [aw-1:0]     rd_ptr;
  logic [data_w-1:0] last_head;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == cw'(depth));
  assign do_pop  = pop & ~empty;
  // A pop in the same clk frees a slot, so a push into a full FIFO is still taken.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? last_head : mem[rd_ptr];

  // Pointers wrap naturally; depth must be a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/reg_we.sv
// rtl/reg_we.sv - resettable register with write enable
//   we/d : load strobe and value;  q : register contents
module reg_we #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         we,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= '0;
    else if (we) q <= d;
  end
endmodule

// File: rtl/spi_slave_shift.sv
// rtl/spi_slave_shift.sv - SPI pin synchronizers, edge detect, frame FSM and byte shifter
//   spi_sck/spi_cs/spi_mosi : async SPI inputs;  spi_miso/spi_miso_oe : SPI outputs
//   en/cpol/cpha/msb_lsb    : live CR fields, mode latched at frame start
//   tx_req/tx_avail/tx_data : byte fetch (tx_req pulses in the load clk)
//   udr_set                 : fetch found no data, 0xFF used instead
//   rx_vld/rx_data          : completed received byte
//   frame_end/busy          : cs released after >=1 byte / frame in progress
module spi_slave_shift
  import spi_slave_pkg::*;
#(
  parameter int sync_w = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       en,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       msb_lsb,
  output logic       tx_req,
  input  logic       tx_avail,
  input  logic [7:0] tx_data,
  output logic       udr_set,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       frame_end,
  output logic       busy
);
  logic [sync_w-1:0] sck_sync, cs_sync, mosi_sync;
  logic              sck_d, cs_d;
  logic              sck_s, cs_s, mosi_s;
  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic              sample_edge, shift_edge, last_bit;
  logic              f_cpol, f_cpha, f_lsb;
  spi_s_state_e      state, state_n;
  logic [2:0]        cnt, out_idx;
  logic [7:0]        tx_sr, rx_sr, rx_next;
  logic              got_byte;

  // All sync flops reset to 0: a cs held low through reset never looks like a
  // falling edge afterwards, so an aborted frame cannot resume mid-byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[sync_w-2:0], spi_sck};
      cs_sync   <= {cs_sync[sync_w-2:0], spi_cs};
      mosi_sync <= {mosi_sync[sync_w-2:0], spi_mosi};
      sck_d     <= sck_sync[sync_w-1];
      cs_d      <= cs_sync[sync_w-1];
    end
  end

  assign sck_s    = sck_sync[sync_w-1];
  assign cs_s     = cs_sync[sync_w-1];
  assign mosi_s   = mosi_sync[sync_w-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  assign sample_edge = (f_cpol == f_cpha) ? sck_rise : sck_fall;
  assign shift_edge  = (f_cpol == f_cpha) ? sck_fall : sck_rise;
  assign last_bit    = sample_edge && (cnt == 3'd7);
  assign rx_next     = f_lsb ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
  assign rx_data     = rx_next;
  assign udr_set     = tx_req & ~tx_avail;
  assign busy        = (state != st_idle);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= st_idle;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tx_req    = 1'b0;
    rx_vld    = 1'b0;
    frame_end = 1'b0;
    case (state)
      st_idle:  if (cs_fall && en) state_n = st_load;
      st_load: begin
        if (cs_rise) state_n = st_idle;
        else begin
          tx_req  = 1'b1;
          state_n = st_shift;
        end
      end
      st_shift: begin
        if (cs_rise) begin
          state_n   = st_idle;
          frame_end = got_byte;
        end else if (last_bit) begin
          rx_vld = 1'b1;
          tx_req = 1'b1;
        end
      end
      default: state_n = st_idle;
    endcase
  end

  // out_idx selects the tx bit on MISO. On a shift edge it takes the number of
  // bits already sampled, which also leaves bit 0 in place on the cpha=1 lead-in
  // edge and after the byte wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_cpol   <= 1'b0;
      f_cpha   <= 1'b0;
      f_lsb    <= 1'b0;
      cnt      <= 3'd0;
      out_idx  <= 3'd0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      got_byte <= 1'b0;
    end else begin
      if (state == st_idle && cs_fall && en) begin
        f_cpol <= cpol;
        f_cpha <= cpha;
        f_lsb  <= msb_lsb;
      end
      if (tx_req) tx_sr <= tx_avail ? tx_data : 8'hFF;
      if (state == st_load) begin
        cnt      <= 3'd0;
        out_idx  <= 3'd0;
        got_byte <= 1'b0;
      end else if (state == st_shift && !cs_rise) begin
        if (sample_edge) begin
          rx_sr <= rx_next;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            out_idx  <= 3'd0;
            got_byte <= 1'b1;
          end
        end else if (shift_edge) begin
          out_idx <= cnt;
        end
      end
    end
  end

  assign spi_miso_oe = busy & ~cs_s & en;
  assign spi_miso    = spi_miso_oe & (f_lsb ? tx_sr[out_idx] : tx_sr[~out_idx]);
endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave peripheral with tx/rx FIFOs, status and interrupt registers
//   clk/rstn                 : system clock, async active-low reset
//   bus                      : register bus (addr/re/we/wd in, rd/irq out)
//   spi_sck/spi_cs/spi_mosi  : SPI inputs from the master
//   spi_miso/spi_miso_oe     : SPI data out and its output enable
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int depth  = spi_s_depth,
  parameter int sync_w = spi_s_sync_w
) (
  input  logic        clk,
  input  logic        rstn,
  spi_slave_if.slave  bus,
  input  logic        spi_sck,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);
  localparam int cw = $clog2(depth+1);

  logic [7:0]    cr_q;
  spi_s_cr_v     cr;
  logic [4:0]    irq_m_q, irq_v_q, irq_v_d;
  spi_s_irq_v    irq_cond;
  spi_s_sr_v     sr;
  logic          sel_cr, sel_dr, sel_sr, sel_irq_m, sel_irq_v;
  logic          irq_v_wr, irq_v_we;
  logic          tx_req, tx_avail, tx_pop, udr_set;
  logic          rx_vld, rx_pop, ovr_set, frame_end, busy;
  logic [7:0]    tx_dout, rx_dout, rx_data;
  logic [cw-1:0] tx_cnt, rx_cnt;
  logic          ovr, udr;
  logic          unused_wd;

  assign unused_wd = ^bus.wd[31:8];

  assign sel_cr    = (bus.addr == addr_cr);
  assign sel_dr    = (bus.addr == addr_dr);
  assign sel_sr    = (bus.addr == addr_sr);
  assign sel_irq_m = (bus.addr == addr_irq_m);
  assign sel_irq_v = (bus.addr == addr_irq_v);

  reg_we #(.w(8)) u_cr (
    .clk(clk), .rstn(rstn), .we(bus.we & sel_cr), .d(bus.wd[7:0]), .q(cr_q));
  assign cr = cr_q;

  reg_we #(.w(5)) u_irq_m (
    .clk(clk), .rstn(rstn), .we(bus.we & sel_irq_m), .d(bus.wd[4:0]), .q(irq_m_q));

  // Hardware set wins over a software write in the same clk.
  assign irq_v_wr = bus.we & sel_irq_v;
  assign irq_v_we = irq_v_wr | (|irq_cond);
  assign irq_v_d  = (irq_v_wr ? bus.wd[4:0] : irq_v_q) | irq_cond;

  reg_we #(.w(5)) u_irq_v (
    .clk(clk), .rstn(rstn), .we(irq_v_we), .d(irq_v_d), .q(irq_v_q));

  assign tx_avail = (tx_cnt != '0);
  assign tx_pop   = tx_req & tx_avail;
  assign rx_pop   = bus.re & sel_dr;

  fifo #(.depth(depth), .data_w(8)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(bus.we & sel_dr), .din(bus.wd[7:0]),
    .pop(tx_pop), .dout(tx_dout), .count(tx_cnt));

  fifo #(.depth(depth), .data_w(8)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_vld), .din(rx_data),
    .pop(rx_pop), .dout(rx_dout), .count(rx_cnt));

  spi_slave_shift #(.sync_w(sync_w)) u_shift (
    .clk(clk), .rstn(rstn),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .en(cr.en), .cpol(cr.cpol), .cpha(cr.cpha), .msb_lsb(cr.msb_lsb),
    .tx_req(tx_req), .tx_avail(tx_avail), .tx_data(tx_dout), .udr_set(udr_set),
    .rx_vld(rx_vld), .rx_data(rx_data), .frame_end(frame_end), .busy(busy));

  // A full rx FIFO still accepts the byte if the bus pops in the same clk.
  assign ovr_set = rx_vld & (rx_cnt == cw'(depth)) & ~rx_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr <= 1'b0;
      udr <= 1'b0;
    end else begin
      if (bus.we && sel_sr) begin
        ovr <= 1'b0;
        udr <= 1'b0;
      end
      if (ovr_set) ovr <= 1'b1;
      if (udr_set) udr <= 1'b1;
    end
  end

  always_comb begin
    sr         = '0;
    sr.rx_emp  = (rx_cnt == '0);
    sr.rx_full = (rx_cnt >= cw'(cr.rx_fifo_lvl));
    sr.tx_emp  = (tx_cnt == '0);
    sr.tx_full = (tx_cnt == cw'(depth));
    sr.ovr     = ovr;
    sr.udr     = udr;
    sr.busy    = busy;
  end

  always_comb begin
    irq_cond           = '0;
    irq_cond.rx_full   = sr.rx_full;
    irq_cond.tx_emp    = sr.tx_emp;
    irq_cond.ovr       = ovr;
    irq_cond.udr       = udr;
    irq_cond.frame_end = frame_end;
    irq_cond           = irq_cond & irq_m_q;
  end

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      addr_cr:    bus.rd = {24'd0, cr_q};
      addr_dr:    bus.rd = {24'd0, rx_dout};
      addr_sr:    bus.rd = {25'd0, sr};
      addr_irq_m: bus.rd = {27'd0, irq_m_q};
      addr_irq_v: bus.rd = {27'd0, irq_v_q};
      default:    bus.rd = '0;
    endcase
  end

  assign bus.irq = |irq_v_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic spi_sck, spi_cs, spi_mosi;
  logic spi_miso, spi_miso_oe;
  logic m_cpol, m_cpha, m_lsb;
  int   n_cmp = 0;
  int   n_err = 0;

  spi_slave_if bus ();

  spi_slave dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.wd = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.re = 1'b1;
    #1 d = bus.rd;
    @(negedge clk);
    bus.re = 1'b0;
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_sck = m_cpol;
    repeat (4) @(negedge clk);
    spi_cs = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic cs_high();
    half();
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    int b;
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = m_lsb ? i : 7 - i;
      if (!m_cpha) begin
        spi_mosi = tx[b];
        half();
        rx[b] = spi_miso;
        spi_sck = ~m_cpol;
        half();
        spi_sck = m_cpol;
      end else begin
        half();
        spi_sck = ~m_cpol;
        spi_mosi = tx[b];
        half();
        rx[b] = spi_miso;
        spi_sck = m_cpol;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv;
    logic [7:0]  rxb;
    logic [2:0]  modes [4];
    logic [2:0]  m;

    modes[0] = 3'b010;  // {lsb, cpha, cpol}: mode 1
    modes[1] = 3'b001;  // mode 2
    modes[2] = 3'b011;  // mode 3
    modes[3] = 3'b100;  // mode 0, LSB first

    rstn = 1'b0;
    bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wd = '0;
    spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // reset state
    #1;
    check("rst miso", spi_miso, 0);
    check("rst oe", spi_miso_oe, 0);
    check("rst irq", bus.irq, 0);
    bus_read(addr_sr, rdv);    check("rst sr", rdv, 32'h07);
    bus_read(addr_cr, rdv);    check("rst cr", rdv, 32'h00);
    bus_read(addr_irq_v, rdv); check("rst irq_v", rdv, 32'h00);

    // mode 0, MSB first, A5 out / 3C in, frame-end irq
    bus_write(addr_cr, 32'h08);
    bus_write(addr_dr, 32'hA5);
    bus_write(addr_irq_m, 32'h10);
    cs_low();
    spi_bits(8'h3C, 8, rxb);
    check("t1 oe in frame", spi_miso_oe, 1);
    check("t1 miso byte", rxb, 8'hA5);
    cs_high();
    check("t1 oe after cs", spi_miso_oe, 0);
    bus_read(addr_sr, rdv);    check("t1 rx_emp", rdv & 32'h1, 0);
    bus_read(addr_irq_v, rdv); check("t1 irq_v", rdv, 32'h10);
    check("t1 irq", bus.irq, 1);
    bus_read(addr_dr, rdv);    check("t1 dr", rdv, 32'h3C);
    bus_write(addr_irq_v, 32'h0);
    #1 check("t1 irq clr", bus.irq, 0);
    bus_write(addr_irq_m, 32'h0);
    bus_write(addr_sr, 32'h0);
    bus_read(addr_sr, rdv);    check("t1 sr clr", rdv & 32'h30, 0);

    // other modes, 81 in / 7E out (second 7E feeds the end-of-byte reload)
    for (int i = 0; i < 4; i++) begin
      m = modes[i];
      m_cpol = m[0]; m_cpha = m[1]; m_lsb = m[2];
      bus_write(addr_cr, {28'h0, 1'b1, m_lsb, m_cpha, m_cpol});
      bus_write(addr_dr, 32'h7E);
      bus_write(addr_dr, 32'h7E);
      cs_low();
      spi_bits(8'h81, 8, rxb);
      cs_high();
      check($sformatf("mode%0d miso", i), rxb, 8'h7E);
      bus_read(addr_dr, rdv); check($sformatf("mode%0d dr", i), rdv, 32'h81);
      bus_read(addr_sr, rdv); check($sformatf("mode%0d ovr_udr", i), rdv & 32'h30, 0);
    end

    // LSB first with an asymmetric pattern
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b1;
    bus_write(addr_cr, 32'h0C);
    bus_write(addr_dr, 32'h34);
    bus_write(addr_dr, 32'h34);
    cs_low();
    spi_bits(8'h12, 8, rxb);
    cs_high();
    check("lsb miso", rxb, 8'h34);
    bus_read(addr_dr, rdv); check("lsb dr", rdv, 32'h12);

    // underrun: empty tx FIFO
    m_lsb = 1'b0;
    bus_write(addr_cr, 32'h08);
    bus_write(addr_irq_m, 32'h08);
    bus_write(addr_irq_v, 32'h0);
    cs_low();
    spi_bits(8'h55, 8, rxb);
    cs_high();
    check("udr miso", rxb, 8'hFF);
    bus_read(addr_sr, rdv);    check("udr sr", (rdv >> 5) & 32'h1, 1);
    bus_read(addr_irq_v, rdv); check("udr irq_v", rdv & 32'h8, 32'h8);
    check("udr irq", bus.irq, 1);
    bus_read(addr_dr, rdv);    check("udr dr", rdv, 32'h55);
    bus_write(addr_sr, 32'h0);
    bus_read(addr_sr, rdv);    check("udr clr", (rdv >> 5) & 32'h1, 0);
    bus_write(addr_irq_v, 32'h0);
    #1 check("udr irq clr", bus.irq, 0);
    bus_write(addr_irq_m, 32'h0);

    // overrun: 9 bytes into an 8-deep rx FIFO, level trigger at 8
    bus_write(addr_cr, 32'h88);
    cs_low();
    for (int k = 1; k <= 9; k++) spi_bits(8'(k * 8'h11), 8, rxb);
    cs_high();
    bus_read(addr_sr, rdv); check("ovr sr", rdv & 32'h13, 32'h12);
    for (int k = 1; k <= 8; k++) begin
      bus_read(addr_dr, rdv);
      check($sformatf("ovr dr%0d", k), rdv, 32'(k * 8'h11));
    end
    bus_read(addr_sr, rdv); check("ovr drained", rdv & 32'h1, 1);
    bus_write(addr_sr, 32'h0);

    // partial byte discarded, next frame aligned
    bus_write(addr_cr, 32'h08);
    cs_low();
    spi_bits(8'hF0, 5, rxb);
    cs_high();
    bus_read(addr_sr, rdv); check("part sr", rdv & 32'h41, 32'h01);
    bus_write(addr_dr, 32'h3A);
    cs_low();
    spi_bits(8'hC3, 8, rxb);
    cs_high();
    check("part miso", rxb, 8'h3A);
    bus_read(addr_dr, rdv); check("part dr", rdv, 32'hC3);

    // async reset mid-byte
    bus_write(addr_dr, 32'h66);
    cs_low();
    spi_bits(8'hAA, 3, rxb);
    #2 rstn = 1'b0;
    #1;
    check("arst miso", spi_miso, 0);
    check("arst oe", spi_miso_oe, 0);
    check("arst irq", bus.irq, 0);
    bus.addr = addr_sr;
    #1 check("arst sr", bus.rd, 32'h07);
    bus.addr = addr_cr;
    #1 check("arst cr", bus.rd, 32'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    spi_bits(8'hAA, 5, rxb);
    cs_high();
    bus_read(addr_sr, rdv); check("arst sr after", rdv, 32'h07);
    bus_write(addr_cr, 32'h08);
    bus_write(addr_dr, 32'h9C);
    cs_low();
    spi_bits(8'h47, 8, rxb);
    cs_high();
    check("arst miso next", rxb, 8'h9C);
    bus_read(addr_dr, rdv); check("arst dr next", rdv, 32'h47);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
